// File: rtl/prog_chain_pkg.sv
// Shared types and sizing helpers for the programming-chain loader.
package prog_chain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_READ = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int w;
    int p;
    w = 32'sd0;
    p = 32'sd1;
    while (p < value) begin
      p = p * 32'sd2;
      w = w + 32'sd1;
    end
    return w;
  endfunction

  // Width of a counter that must hold 0..max_value inclusive.
  function automatic int cnt_width(input int max_value);
    return (clog2(max_value + 32'sd1) < 32'sd1) ? 32'sd1 : clog2(max_value + 32'sd1);
  endfunction

  function automatic int num_words(input int chain_len, input int word_w);
    return (chain_len + word_w - 32'sd1) / word_w;
  endfunction

  function automatic int tail_bits(input int chain_len, input int word_w);
    return chain_len - (num_words(chain_len, word_w) - 32'sd1) * word_w;
  endfunction

endpackage

// File: rtl/prog_word_serializer.sv
// MSB-first load/shift buffer; the counter holds bits still to be shifted.
module prog_word_serializer
  import prog_chain_pkg::*;
#(
  parameter int WORD_W = 8,
  localparam int CNT_W = cnt_width(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic [CNT_W-1:0]  len,
  output logic              serial_bit,
  output logic              empty,
  output logic              last_bit
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [WORD_W-1:0] word_r;
  logic [CNT_W-1:0]  cnt_r;

  // Buffer/counter update; a load on the final bit replaces it with no bubble.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      word_r <= '0;
      cnt_r  <= '0;
    end else if (load) begin
      word_r <= word;
      cnt_r  <= len;
    end else if (cnt_r != '0) begin
      word_r <= word_r << 1'b1;
      cnt_r  <= cnt_r - CNT_ONE;
    end else begin
      word_r <= word_r;
      cnt_r  <= cnt_r;
    end
  end

  // Discarded low bits are zero, so an empty buffer presents a 0 MSB.
  assign serial_bit = word_r[WORD_W-1];
  assign empty      = (cnt_r == '0);
  assign last_bit   = (cnt_r == CNT_ONE);

endmodule

// File: rtl/prog_chain_loader.sv
// Serial configuration-chain loader. Optional non-destructive readback of
// the chain is built when PROG_READBACK_EN is defined.
module prog_chain_loader
  import prog_chain_pkg::*;
#(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              chain_in,
  output logic              chain_en,
  input  logic              chain_tail,
  output logic              busy,
  output logic              done
`ifdef PROG_READBACK_EN
  ,
  input  logic              rb_start,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  localparam int NUM_WORDS = num_words(CHAIN_LEN, WORD_W);
  localparam int TAIL_BITS = tail_bits(CHAIN_LEN, WORD_W);
  localparam int BIT_CW    = cnt_width(WORD_W);
  localparam int WRD_CW    = cnt_width(NUM_WORDS);

  localparam logic [BIT_CW-1:0] LEN_FULL   = BIT_CW'(WORD_W);
  localparam logic [BIT_CW-1:0] LEN_TAIL   = BIT_CW'(TAIL_BITS);
  localparam logic [WRD_CW-1:0] WORDS_ALL  = WRD_CW'(NUM_WORDS);
  localparam logic [WRD_CW-1:0] WORDS_LAST = WRD_CW'(NUM_WORDS - 1);
  localparam logic [WRD_CW-1:0] WRD_ONE    = WRD_CW'(1'b1);
  localparam logic [WORD_W-1:0] TAIL_MASK  = {WORD_W{1'b1}} << (WORD_W - TAIL_BITS);

  state_e              state_r;
  state_e              state_s;
  logic                start_ok_s;
  logic [WRD_CW-1:0]   words_r;
  logic                words_left_s;
  logic                last_word_s;
  logic                accept_s;
  logic [WORD_W-1:0]   load_word_s;
  logic [BIT_CW-1:0]   load_len_s;
  logic                ser_bit_s;
  logic                ser_empty_s;
  logic                ser_last_s;

  assign words_left_s = (words_r != WORDS_ALL);
  assign last_word_s  = (words_r == WORDS_LAST);
  assign cfg_ready    = (state_r == ST_LOAD) && (ser_empty_s || ser_last_s) && words_left_s;
  assign accept_s     = cfg_valid && cfg_ready;
  assign load_word_s  = last_word_s ? (cfg_data & TAIL_MASK) : cfg_data;
  assign load_len_s   = last_word_s ? LEN_TAIL : LEN_FULL;

  prog_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk        (clk),
    .rst        (rst),
    .flush      (start_ok_s),
    .load       (accept_s),
    .word       (load_word_s),
    .len        (load_len_s),
    .serial_bit (ser_bit_s),
    .empty      (ser_empty_s),
    .last_bit   (ser_last_s)
  );

`ifdef PROG_READBACK_EN
  localparam int CL_CW = cnt_width(CHAIN_LEN);
  localparam logic [CL_CW-1:0]  CHAIN_LAST = CL_CW'(CHAIN_LEN - 1);
  localparam logic [CL_CW-1:0]  CL_ONE     = CL_CW'(1'b1);
  localparam logic [BIT_CW-1:0] BIT_LAST   = BIT_CW'(WORD_W - 1);
  localparam logic [BIT_CW-1:0] BIT_ONE    = BIT_CW'(1'b1);

  logic [CL_CW-1:0]  rd_cnt_r;
  logic [BIT_CW-1:0] rd_bit_r;
  logic [WORD_W-1:0] cap_r;
  logic [WORD_W-1:0] cap_s;
  logic [WORD_W-1:0] rb_data_r;
  logic              rb_valid_r;
  logic              rd_last_s;
  logic              rd_emit_s;

  assign rd_last_s = (rd_cnt_r == CHAIN_LAST);
  assign rd_emit_s = rd_last_s || (rd_bit_r == BIT_LAST);

  // Capture word with the current tail bit appended at the LSB.
  always_comb begin
    cap_s    = cap_r << 1'b1;
    cap_s[0] = chain_tail;
  end

  // Readback counters and word output; the final partial word is left-aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_r   <= '0;
      rd_bit_r   <= '0;
      cap_r      <= '0;
      rb_data_r  <= '0;
      rb_valid_r <= 1'b0;
    end else if (state_r == ST_READ) begin
      cap_r      <= cap_s;
      rd_cnt_r   <= rd_last_s ? '0 : (rd_cnt_r + CL_ONE);
      rd_bit_r   <= rd_emit_s ? '0 : (rd_bit_r + BIT_ONE);
      rb_valid_r <= rd_emit_s;
      rb_data_r  <= rd_emit_s ? (cap_s << (BIT_LAST - rd_bit_r)) : rb_data_r;
    end else begin
      rd_cnt_r   <= '0;
      rd_bit_r   <= '0;
      cap_r      <= cap_r;
      rb_data_r  <= rb_data_r;
      rb_valid_r <= 1'b0;
    end
  end

  assign rb_data  = rb_data_r;
  assign rb_valid = rb_valid_r;
  assign chain_en = !ser_empty_s || (state_r == ST_READ);
  assign chain_in = (state_r == ST_READ) ? chain_tail : ser_bit_s;
`else
  logic tail_unused_s;
  assign tail_unused_s = chain_tail;
  assign chain_en      = !ser_empty_s;
  assign chain_in      = ser_bit_s;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; start is honoured only from IDLE or DONE.
  always_comb begin
    state_s    = state_r;
    start_ok_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s    = ST_LOAD;
          start_ok_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (!words_left_s && ser_last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_s    = ST_LOAD;
          start_ok_s = 1'b1;
`ifdef PROG_READBACK_EN
        end else if (rb_start) begin
          state_s = ST_READ;
`endif
        end else begin
          state_s = ST_DONE;
        end
      end
`ifdef PROG_READBACK_EN
      ST_READ: begin
        if (rd_last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_READ;
        end
      end
`endif
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Word counter: cleared on an accepted start, advanced per accepted word.
  always_ff @(posedge clk) begin
    if (rst || start_ok_s) begin
      words_r <= '0;
    end else if (accept_s) begin
      words_r <= words_r + WRD_ONE;
    end else begin
      words_r <= words_r;
    end
  end

  assign busy = (state_r == ST_LOAD) || (state_r == ST_READ);
  assign done = (state_r == ST_DONE) || (state_r == ST_READ);

endmodule

// File: tb/tb_prog_chain_loader.sv
// Directed bench for prog_chain_loader with a 20-bit chain model (five 4-bit cells).
module tb_prog_chain_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       chain_in;
  logic       chain_en;
  logic       chain_tail;
  logic       busy;
  logic       done;
`ifdef PROG_READBACK_EN
  logic       rb_start;
  logic [7:0] rb_data;
  logic       rb_valid;
`endif

  logic [19:0] sr = 20'h0;
  logic        exp_bits[$];
  logic [7:0]  exp_rb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int en_cnt = 0;
  int rd_cyc = 0;
  int acc_cyc = 0;

  prog_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_data   (cfg_data),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .chain_in   (chain_in),
    .chain_en   (chain_en),
    .chain_tail (chain_tail),
    .busy       (busy),
    .done       (done)
`ifdef PROG_READBACK_EN
    ,
    .rb_start   (rb_start),
    .rb_data    (rb_data),
    .rb_valid   (rb_valid)
`endif
  );

  always #5 clk = ~clk;

  // Chain of cells: first cell at sr[0], last cell output at sr[19].
  always @(posedge clk) begin
    if (chain_en === 1'b1) sr <= {sr[18:0], chain_in};
  end
  assign chain_tail = sr[19];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: wait for the falling edge, then scoreboard the DUT outputs.
  task automatic step();
    logic b;
    @(negedge clk);
    cyc++;
    if (chain_en === 1'b1) begin
      en_cnt++;
      if (done === 1'b0) begin
        if (exp_bits.size() == 0) chk("chain_en_extra", {31'd0, chain_en}, 32'd0);
        else begin
          b = exp_bits.pop_front();
          chk("chain_bit", {31'd0, chain_in}, {31'd0, b});
        end
      end
    end
`ifdef PROG_READBACK_EN
    if (rb_valid === 1'b1) begin
      if (exp_rb.size() == 0) chk("rb_valid_extra", {31'd0, rb_valid}, 32'd0);
      else chk("rb_word", {24'd0, rb_data}, {24'd0, exp_rb.pop_front()});
    end
`endif
    if (busy === 1'b1 && done === 1'b1) rd_cyc++;
  endtask

  task automatic send(input logic [7:0] w, input int nbits);
    int g;
    g = 0;
    cfg_data  = w;
    cfg_valid = 1'b1;
    while (cfg_ready !== 1'b1 && g < 50) begin
      step();
      g++;
    end
    chk("ready_wait", {31'd0, cfg_ready}, 32'd1);
    for (int i = 0; i < nbits; i++) exp_bits.push_back(w[7-i]);
    step();
    acc_cyc   = cyc;
    cfg_valid = 1'b0;
  endtask

  task automatic begin_load();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a, 8);
    send(b, 8);
    send(c, 4);
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (done !== 1'b1 && g < 200) begin
      step();
      g++;
    end
    chk("done_wait", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int a0;
    int en0;
    int g;
    rst = 1'b1; start = 1'b0; cfg_data = 8'h00; cfg_valid = 1'b0;
`ifdef PROG_READBACK_EN
    rb_start = 1'b0;
`endif
    step();
    step();
    chk("reset_outs", {27'd0, cfg_ready, chain_in, chain_en, busy, done}, 32'd0);
`ifdef PROG_READBACK_EN
    chk("reset_rb", {23'd0, rb_valid, rb_data}, 32'd0);
`endif
    rst = 1'b0;
    // Words offered in IDLE are refused.
    cfg_valid = 1'b1; cfg_data = 8'hFF;
    step();
    chk("idle_no_ready", {30'd0, cfg_ready, chain_en}, 32'd0);
    cfg_valid = 1'b0;
    // rst wins over start.
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    chk("rst_beats_start", {31'd0, busy}, 32'd0);

    // Back-to-back load with precise completion timing.
    en0 = en_cnt;
    begin_load();
    chk("start_busy", {30'd0, busy, done}, 32'd2);
    send(8'hA5, 8);
    a0 = acc_cyc;
    send(8'h3C, 8);
    send(8'hF0, 4);
    chk("ready_low_after_last", {31'd0, cfg_ready}, 32'd0);
    while (cyc < a0 + 19) step();
    chk("done_not_early", {31'd0, done}, 32'd0);
    step();
    chk("done_on_time", {29'd0, done, busy, cfg_ready}, 32'd4);
    chk("en_count_1", en_cnt - en0, 32'd20);
    chk("cells_1", {12'd0, sr}, {12'd0, 8'hA5, 8'h3C, 4'hF});
    chk("queue_empty_1", exp_bits.size(), 32'd0);

    // Load with 3 idle cycles between words: the chain holds.
    en0 = en_cnt;
    begin_load();
    send(8'hA5, 8);
    for (int w = 0; w < 2; w++) begin
      g = 0;
      while (chain_en === 1'b1 && g < 20) begin
        step();
        g++;
      end
      for (int k = 0; k < 3; k++) begin
        chk("gap_hold", {30'd0, chain_en, chain_in}, 32'd0);
        if (k < 2) step();
      end
      if (w == 0) send(8'h3C, 8);
      else send(8'hF0, 4);
    end
    wait_done();
    chk("en_count_2", en_cnt - en0, 32'd20);
    chk("cells_2", {12'd0, sr}, {12'd0, 8'hA5, 8'h3C, 4'hF});

    // start while busy is ignored.
    en0 = en_cnt;
    begin_load();
    send(8'hA5, 8);
    send(8'h3C, 8);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_ignored", {30'd0, busy, done}, 32'd2);
    send(8'hF0, 4);
    wait_done();
    chk("en_count_3", en_cnt - en0, 32'd20);
    chk("cells_3", {12'd0, sr}, {12'd0, 8'hA5, 8'h3C, 4'hF});

    // Reset after 10 shifted bits, then reload with zeros.
    en0 = en_cnt;
    begin_load();
    send(8'hA5, 8);
    send(8'h3C, 8);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_outs", {29'd0, chain_en, done, busy}, 32'd0);
    chk("mid_rst_bits", en_cnt - en0, 32'd10);
    exp_bits.delete();
    begin_load();
    send3(8'h00, 8'h00, 8'h00);
    wait_done();
    chk("cells_zero", {12'd0, sr}, 32'd0);

    // Restart from DONE overwrites the chain.
    begin_load();
    send3(8'h12, 8'h34, 8'h56);
    wait_done();
    chk("cells_4", {12'd0, sr}, {12'd0, 8'h12, 8'h34, 4'h5});
    begin_load();
    chk("restart_clears_done", {30'd0, busy, done}, 32'd2);
    send3(8'hC3, 8'h96, 8'h7E);
    wait_done();
    chk("cells_5", {12'd0, sr}, {12'd0, 8'hC3, 8'h96, 4'h7});

`ifdef PROG_READBACK_EN
    begin_load();
    send3(8'hA5, 8'h3C, 8'hF0);
    wait_done();
    exp_rb.push_back(8'hA5);
    exp_rb.push_back(8'h3C);
    exp_rb.push_back(8'hF0);
    en0 = en_cnt;
    g = rd_cyc;
    rb_start = 1'b1;
    step();
    rb_start = 1'b0;
    chk("read_state", {30'd0, busy, done}, 32'd3);
    a0 = 0;
    while (busy === 1'b1 && a0 < 100) begin
      step();
      a0++;
    end
    chk("read_cycles", rd_cyc - g, 32'd20);
    chk("read_en_count", en_cnt - en0, 32'd20);
    chk("read_after", {30'd0, busy, done}, 32'd1);
    chk("read_cells", {12'd0, sr}, {12'd0, 8'hA5, 8'h3C, 4'hF});
    chk("rb_all_seen", exp_rb.size(), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
